// File: rtl/ula_seq.sv
// ============================================================================
//  Module   : ula_seq
//  Purpose  : Sequential ALU with a Start/Busy/Done handshake. ADD, SUB, NAND,
//             PASS A and PASS Ry complete at the accepting edge. MUL (iterative
//             shift-add) and multi-bit shifts (one bit per edge) run in EXEC.
//             Result and flags are registered and only change when Done fires.
//  Ports    : Clock    - rising-edge clock
//             Resetn   - synchronous active-low reset
//             Start    - request, sampled only while Busy=0
//             OpSelect - operation code [0:2], bit 0 = MSB
//             A, Ry    - operands [0:WIDTH-1], index 0 = MSB (Ry also gives
//                        the shift amount in its low SHW bits)
//             Result   - registered result
//             Busy     - high while a multi-cycle operation iterates
//             Done     - one-cycle pulse, Result/flags valid from this cycle
//             Zero, Negative, Carry, Overflow - registered status flags
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_seq #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [0:2]       OpSelect,
    input  logic [0:WIDTH-1] A,
    input  logic [0:WIDTH-1] Ry,
    output logic [0:WIDTH-1] Result,
    output logic             Busy,
    output logic             Done,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] c_OP_ADD   = 3'b000;
    localparam logic [2:0] c_OP_SUB   = 3'b001;
    localparam logic [2:0] c_OP_NAND  = 3'b010;
    localparam logic [2:0] c_OP_MUL   = 3'b011;
    localparam logic [2:0] c_OP_PASSA = 3'b100;
    localparam logic [2:0] c_OP_PASSB = 3'b101;
    localparam logic [2:0] c_OP_SHL   = 3'b110;
    localparam logic [2:0] c_OP_SHR   = 3'b111;

    localparam logic [SHW:0] c_CNT_FULL = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] c_CNT_ONE  = (SHW+1)'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input views with conventional [MSB:0] numbering. The value is the
    // same; only the index direction differs from the port declaration.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_opsel;
    logic [SHW-1:0]   w_n;

    assign w_a     = A;
    assign w_b     = Ry;
    assign w_opsel = OpSelect;
    assign w_n     = w_b[SHW-1:0];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [2:0]         r_op;
    logic [SHW:0]       r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_shv;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;
    logic               r_zero;
    logic               r_neg;
    logic               r_carry;
    logic               r_ovf;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs so the result
    // can be registered at the accepting edge itself.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_c;
    logic             w_sc_v;

    assign w_sum = {1'b0, w_a} + {1'b0, w_b};
    // Subtraction as A + ~Ry + 1 so the carry-out means "no borrow".
    assign w_dif = {1'b0, w_a} + {1'b0, ~w_b} + (WIDTH+1)'(1);

    always_comb begin
        w_sc_res = w_a;
        w_sc_c   = 1'b0;
        w_sc_v   = 1'b0;
        case (w_opsel)
            c_OP_ADD: begin
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_c   = w_sum[WIDTH];
                w_sc_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_sc_res = w_dif[WIDTH-1:0];
                w_sc_c   = w_dif[WIDTH];
                w_sc_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                           (w_dif[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_OP_NAND:  w_sc_res = ~(w_a & w_b);
            c_OP_PASSA: w_sc_res = w_a;
            c_OP_PASSB: w_sc_res = w_b;
            // Shifts only reach this path with n=0, where A passes through.
            default:    w_sc_res = w_a;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative datapath: one step per EXEC edge
    // ------------------------------------------------------------------
    logic               w_is_mul;
    logic               w_is_shift;
    logic               w_multi;
    logic [2*WIDTH-1:0] w_prod_step;
    logic [WIDTH-1:0]   w_shv_step;
    logic               w_sh_out;
    logic               w_last;

    assign w_is_mul   = (w_opsel == c_OP_MUL);
    assign w_is_shift = (w_opsel == c_OP_SHL) || (w_opsel == c_OP_SHR);
    assign w_multi    = w_is_mul || (w_is_shift && (w_n != '0));

    // Full 2*WIDTH product is kept so the upper half can drive Overflow.
    assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_shv_step  = (r_op == c_OP_SHR) ? {1'b0, r_shv[WIDTH-1:1]}
                                            : {r_shv[WIDTH-2:0], 1'b0};
    assign w_sh_out    = (r_op == c_OP_SHR) ? r_shv[0] : r_shv[WIDTH-1];
    assign w_last      = (r_cnt == c_CNT_ONE);

    // ------------------------------------------------------------------
    // Next-state and datapath-update logic
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_load;
    logic [WIDTH-1:0]   w_res_nxt;
    logic               w_c_nxt;
    logic               w_v_nxt;
    logic [2:0]         w_op_nxt;
    logic [SHW:0]       w_cnt_nxt;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [2*WIDTH-1:0] w_mcand_nxt;
    logic [WIDTH-1:0]   w_mplier_nxt;
    logic [WIDTH-1:0]   w_shv_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        w_res_nxt    = r_result;
        w_c_nxt      = r_carry;
        w_v_nxt      = r_ovf;
        w_op_nxt     = r_op;
        w_cnt_nxt    = r_cnt;
        w_prod_nxt   = r_prod;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_shv_nxt    = r_shv;

        unique case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (w_multi) begin
                        // Latch everything; later input changes are ignored.
                        w_state_nxt  = S_EXEC;
                        w_busy_nxt   = 1'b1;
                        w_op_nxt     = w_opsel;
                        w_cnt_nxt    = w_is_mul ? c_CNT_FULL : {1'b0, w_n};
                        w_prod_nxt   = '0;
                        w_mcand_nxt  = {{WIDTH{1'b0}}, w_a};
                        w_mplier_nxt = w_b;
                        w_shv_nxt    = w_a;
                    end else begin
                        w_load     = 1'b1;
                        w_done_nxt = 1'b1;
                        w_res_nxt  = w_sc_res;
                        w_c_nxt    = w_sc_c;
                        w_v_nxt    = w_sc_v;
                    end
                end
            end
            S_EXEC: begin
                w_cnt_nxt    = r_cnt - c_CNT_ONE;
                w_prod_nxt   = w_prod_step;
                w_mcand_nxt  = {r_mcand[2*WIDTH-2:0], 1'b0};
                w_mplier_nxt = {1'b0, r_mplier[WIDTH-1:1]};
                w_shv_nxt    = w_shv_step;
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_load      = 1'b1;
                    if (r_op == c_OP_MUL) begin
                        w_res_nxt = w_prod_step[WIDTH-1:0];
                        w_c_nxt   = 1'b0;
                        w_v_nxt   = |w_prod_step[2*WIDTH-1:WIDTH];
                    end else begin
                        w_res_nxt = w_shv_step;
                        w_c_nxt   = w_sh_out;
                        w_v_nxt   = 1'b0;
                    end
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers. Reset mid-EXEC simply drops the work
    // in progress; Done stays low because it is cleared here too.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_shv    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_op     <= w_op_nxt;
            r_cnt    <= w_cnt_nxt;
            r_prod   <= w_prod_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_shv    <= w_shv_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            if (w_load) begin
                r_result <= w_res_nxt;
                r_zero   <= (w_res_nxt == '0);
                r_neg    <= w_res_nxt[WIDTH-1];
                r_carry  <= w_c_nxt;
                r_ovf    <= w_v_nxt;
            end
        end
    end

    assign Result   = r_result;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Zero     = r_zero;
    assign Negative = r_neg;
    assign Carry    = r_carry;
    assign Overflow = r_ovf;

endmodule

`default_nettype wire
